// File: rtl/intc_vectored_pkg.sv
// ---------------------------------------------------------------------------
// intc_pkg: shared types and constants for the vectored interrupt controller.
//   state_e  - controller FSM state; the encoding is what STAT[31:30] reports
//   REG_*    - register word offsets, matched against bus address bits [3:2]
//   ID_W     - width of a source id
// ---------------------------------------------------------------------------
package intc_pkg;

  localparam int ID_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SERV = 2'b10
  } state_e;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

endpackage

// File: rtl/intc_vectored_if.sv
// ---------------------------------------------------------------------------
// intc_vectored_if: register bus plus the core-side request/accept pair.
//   a, we, wd, rd            - four-word register window (rd is combinational)
//   irq, iack                - committed request / one-cycle accept pulse
//   vector, active_id        - handler address and id of the committed source
// master: core / bus decoder side. slave: the controller.
// ---------------------------------------------------------------------------
interface intc_vectored_if;

  logic [1:0]                a;
  logic                      we;
  logic [31:0]               wd;
  logic [31:0]               rd;
  logic                      irq;
  logic                      iack;
  logic [31:0]               vector;
  logic [intc_pkg::ID_W-1:0] active_id;

  modport master (
    output a, we, wd, iack,
    input  rd, irq, vector, active_id
  );

  modport slave (
    input  a, we, wd, iack,
    output rd, irq, vector, active_id
  );

endinterface

// File: rtl/intc_vectored_pend_cell.sv
// ---------------------------------------------------------------------------
// intc_pend_cell: pending state for one interrupt source.
//   clk, rst  - clock, synchronous active-high reset
//   src_i     - interrupt line, already synchronous to clk
//   clr_i     - clear request (W1C write or accept of this source)
//   pend_o    - pending flag
// Edge mode latches a rising edge; a new edge beats a same-cycle clear.
// Level mode passes the line straight through and the flops go unused.
// ---------------------------------------------------------------------------
module intc_pend_cell #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  input  logic clr_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (src_i && !prev_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= src_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = EDGE ? pend_q : src_i;

endmodule

// File: rtl/intc_vectored.sv
// ---------------------------------------------------------------------------
// intc_vectored: N-source vectored interrupt controller for the mips core.
//   clk, rst  - clock, synchronous active-high reset
//   src       - N_SRC interrupt lines, synchronous to clk
//   bus       - intc_vectored_if.slave: register window (a/we/wd/rd) and
//               core handshake (irq/iack/vector/active_id)
// Lowest eligible index wins. A request is committed in REQ, held in-service
// in SERV until an EOI write, then the controller returns to IDLE.
// ---------------------------------------------------------------------------
module intc_vectored
  import intc_pkg::*;
#(
  parameter int          N_SRC      = 8,
  parameter logic [31:0] EDGE_MASK  = 32'h0000_00FF,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0180,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src,
  intc_vectored_if.slave     bus
);

  localparam bit STRIDE_POW2 = (VEC_STRIDE != 0) && ((VEC_STRIDE & (VEC_STRIDE - 1)) == 0);
  localparam int STRIDE_SH   = (VEC_STRIDE > 1) ? $clog2(VEC_STRIDE) : 0;

  state_e            state_q, state_d;
  logic              irq_q, irq_d;
  logic [31:0]       vector_q, vector_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_SRC-1:0]  mask_q, mask_d;

  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  clr;
  logic [N_SRC-1:0]  elig;
  logic [ID_W-1:0]   winner;
  logic              any_elig;
  logic [31:0]       win_vec;
  logic              wr_pend, wr_mask, wr_eoi, ack;
  logic              unused_wd;

  assign wr_pend = bus.we && (bus.a == REG_PEND);
  assign wr_mask = bus.we && (bus.a == REG_MASK);
  assign wr_eoi  = bus.we && (bus.a == REG_EOI);
  // Accept only counts while a request is committed.
  assign ack     = bus.iack && (state_q == REQ);
  assign unused_wd = ^bus.wd;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign clr[i] = (wr_pend && bus.wd[i]) || (ack && (id_q == ID_W'(i)));

    intc_pend_cell #(
      .EDGE (EDGE_MASK[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .src_i  (src[i]),
      .clr_i  (clr[i]),
      .pend_o (pend[i])
    );
  end

  assign elig     = pend & mask_q;
  assign any_elig = |elig;

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  if (STRIDE_POW2) begin : g_vec_shift
    assign win_vec = VEC_BASE + ({{(32-ID_W){1'b0}}, winner} << STRIDE_SH);
  end else begin : g_vec_mul
    assign win_vec = VEC_BASE + ({{(32-ID_W){1'b0}}, winner} * 32'(VEC_STRIDE));
  end

  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = bus.wd[N_SRC-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      vector_q <= VEC_BASE;
      id_q     <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      vector_q <= vector_d;
      id_q     <= id_d;
      mask_q   <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_elig)  state_d = REQ;
      REQ:     if (bus.iack)  state_d = SERV;
      SERV:    if (wr_eoi)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Request outputs only change when a request is committed or accepted.
  always_comb begin
    irq_d    = irq_q;
    vector_d = vector_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (any_elig) begin
          irq_d    = 1'b1;
          id_d     = winner;
          vector_d = win_vec;
        end
      end
      REQ: begin
        if (bus.iack) irq_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      REG_PEND: bus.rd[N_SRC-1:0] = pend;
      REG_MASK: bus.rd[N_SRC-1:0] = mask_q;
      REG_STAT: bus.rd = {state_q, 25'b0, id_q};
      default:  bus.rd = vector_q;
    endcase
  end

  assign bus.irq       = irq_q;
  assign bus.vector    = vector_q;
  assign bus.active_id = id_q;

endmodule

// File: doc/intc_vectored.md
# intc_vectored

Parametrised, N-source vectored interrupt controller placed between peripheral interrupt lines and the mips core's single `irq`/`iack` pair.
- Latches and masks up to 32 sources, each configured as edge or level, and selects the highest-priority pending source (lowest index wins).
- Presents one committed request with a precomputed handler vector.
- Holds that source as in-service until software writes end-of-interrupt (EOI).
- Exposes a four-word memory-mapped register window on the data-memory bus.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources, legal range 1..32.
- `EDGE_MASK`, 32'h0000_00FF: bit i = 1 makes source i rising-edge; bit i = 0 makes it level-high.
- `VEC_BASE`, 32'h0000_0180: vector of source 0.
- `VEC_STRIDE`, 8: byte spacing between vectors.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  N_SRC  interrupt lines, already synchronous to `clk`.
- `a`  in  2  register word select (bus address bits [3:2]).
- `we`  in  1  register write strobe; must already be qualified by the address decoder.
- `wd`  in  32  write data.
- `rd`  out  32  read data; combinational from `a`.
- `irq`  out  1  request to the core; registered.
- `iack`  in  1  one-cycle accept pulse from the core (rfe[1]).
- `vector`  out  32  handler address of the committed request; registered.
- `active_id`  out  5  id of the committed or in-service source; registered.

## Operation
Register map, selected by `a`:
- 0 PEND
  - Read: pending bits.
  - Write: 1-to-clear edge bits only; level bits ignore writes.
- 1 MASK: RW; bit = 1 enables the source; bits at or above N_SRC read 0.
- 2 STAT: read {state[1:0] in bits 31:30, 25'b0, active_id}; writes ignored.
- 3 EOI
  - Write (any data): ends service.
  - Read: returns `vector`.

Pending:
- Edge source: pend[i] is set when src[i]=1 and the previous sample was 0. It is cleared by a W1C write or by `iack` when `active_id`=i. If set and clear occur in the same cycle, set wins.
- Level source: pend[i] = src[i], not stored.
- Eligible sources: pend & MASK. Selection is the lowest eligible index.

State machine (IDLE, REQ, SERV):
- IDLE:
  - If any source is eligible, go to REQ.
  - Register `irq`=1, `active_id`=winner, `vector`=VEC_BASE + winner*VEC_STRIDE. The addition is 32-bit modulo.
- REQ:
  - The request is committed: `irq`, `vector` and `active_id` hold even if the source drops or is masked.
  - `iack`=1: go to SERV, `irq`=0, and clear the edge pending bit of `active_id`.
  - An EOI write is ignored.
- SERV:
  - No new request is raised. There is no nesting.
  - An EOI write returns to IDLE.
  - `iack` is ignored.
- `iack` in IDLE is ignored.

## Timing
- Reset values: `irq`=0, `vector`=VEC_BASE, `active_id`=0, state IDLE, PEND=0, MASK=0, previous samples=0. Reset mid-REQ or mid-SERV drops `irq` on the next edge, and all edge pending bits are lost.
- Latency: an edge seen on `src` at edge t sets pend at t and raises `irq` at t+1 (enable bit already set). A level source with MASK set raises `irq` one cycle after it is sampled high.
- MASK written at t takes effect for selection from t+1.
- `iack` at edge t: `irq` low after t.
- EOI at edge t: IDLE after t. If another source is eligible, `irq` rises again after t+1. The minimum request gap is 2 cycles.
- A W1C write and `iack` hitting the same edge bit in the same cycle both clear it. A new edge in that cycle still wins.
- `rd` is valid in the same cycle as `a`. A read of PEND during a write returns the pre-write value.

## Structure
- Package `intc_pkg`:
  - State enum IDLE/REQ/SERV with encoding 2'b00/01/10, matching the STAT encoding.
  - Register offsets REG_PEND=0, REG_MASK=1, REG_STAT=2, REG_EOI=3.
  - ID_W=5.
- Sub-module `intc_pend_cell`: one per source, generated `N_SRC` times. It contains the edge/level select, the previous-sample flop, and the pending flop with set-over-clear priority.
- The top level contains the priority encoder, the vector multiply-add (shift when VEC_STRIDE is a power of two), the FSM, and the register decode.

## Test plan
- Reset, then read all four registers: PEND=0, MASK=0, STAT=0, EOI-read=32'h180; `irq`=0.
- MASK=8'h0C; rising edge on src[3] then src[2] one cycle later:
  - `irq` rises with `active_id`=3 and `vector`=32'h198.
  - After `iack` and EOI, the next request is `active_id`=2, `vector`=32'h190.
  - Exactly 2 cycles lie between the EOI write and `irq`.
- src[2] and src[5] pulse in the same cycle with MASK=8'hFF: id 2 is served first; PEND reads 8'h20 during SERV.
- N_SRC=8, EDGE_MASK=8'h7F, MASK=8'h80, src[7] held high:
  - After `iack` and EOI, `irq` re-asserts 2 cycles later.
  - Dropping src[7] while in REQ leaves `irq` and `vector`=32'h1B8 held until `iack`.
- Edges on src[1] at the same cycle as a W1C write of 8'h02: PEND[1] stays 1. Assert `rst` while in SERV: next cycle `irq`=0, STAT=0, and PEND=0.
